mux16_rr_ctrl: RTL and testbench

MUX16_RR_CTRL -- requirements
Module: mux16_rr_ctrl

---
 rtl/mux16_pkg.sv | 21 ++
 rtl/mux16to1.sv | 16 +
 rtl/mux16_rr_ctrl.sv | 132 +++++++++++++
 tb/tb_mux16_rr_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_pkg.sv
// rtl/mux16_pkg.sv - shared constants, FSM state type and helpers for the 16-channel round-robin mux
package mux16_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        SEND = 2'd2
    } state_t;

    // One-hot vector with only bit idx set.
    function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NCH-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux16to1.sv
// rtl/mux16to1.sv - 16:1 single-bit data multiplexer
// Ports:
//   din [15:0] : one data bit per channel
//   sel [3:0]  : channel index
//   out        : din[sel]
import mux16_pkg::*;

module mux16to1 (
    input  logic [NCH-1:0]   din,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    assign out = din[sel];

endmodule

// File: rtl/mux16_rr_ctrl.sv
// rtl/mux16_rr_ctrl.sv - round-robin arbiter capturing one data bit per grant through a 16:1 mux
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   req [15:0]         : per-channel level request
//   din [15:0]         : per-channel data bit
//   cfg_we, cfg_mask   : channel-enable mask write
//   out_ready          : downstream accept (only looked at while presenting)
//   out_valid/data/chan: presented transfer
//   gnt [15:0]         : one-cycle one-hot completion pulse
//   busy               : a transfer is in flight
import mux16_pkg::*;

module mux16_rr_ctrl #(
    parameter logic [NCH-1:0] MASK_RST = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   din,
    input  logic             cfg_we,
    input  logic [NCH-1:0]   cfg_mask,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_data,
    output logic [SEL_W-1:0] out_chan,
    output logic [NCH-1:0]   gnt,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             out_valid_q, out_valid_d;
    logic             out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [NCH-1:0]   gnt_q, gnt_d;

    logic [NCH-1:0]   elig;
    logic             rr_hit;
    logic [SEL_W-1:0] rr_pick;
    logic [SEL_W-1:0] rr_idx;
    logic             mux_out;

    mux16to1 u_mux (
        .din (din),
        .sel (sel_q),
        .out (mux_out)
    );

    // Search starts just past the last winner; i = NCH wraps back onto ptr
    // itself so the previous winner is considered last.
    always_comb begin
        elig    = req & mask_q;
        rr_hit  = 1'b0;
        rr_pick = ptr_q;
        rr_idx  = ptr_q;
        for (int i = 1; i <= NCH; i++) begin
            rr_idx = ptr_q + SEL_W'(i);
            if (!rr_hit && elig[rr_idx]) begin
                rr_hit  = 1'b1;
                rr_pick = rr_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        gnt_d       = '0;
        // Arbitration above reads mask_q, so a write lands after this edge.
        mask_d      = cfg_we ? cfg_mask : mask_q;

        case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    sel_d   = rr_pick;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                out_data_d  = mux_out;
                out_chan_d  = sel_q;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                // req/mask are not consulted here: a granted transfer always completes.
                if (out_ready) begin
                    gnt_d       = onehot(sel_q);
                    ptr_d       = sel_q;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= SEL_W'(NCH - 1);
            sel_q       <= '0;
            mask_q      <= MASK_RST;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_chan_q  <= '0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            gnt_q       <= gnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux16_rr_ctrl.sv
// tb/tb_mux16_rr_ctrl.sv - self-checking bench for mux16_rr_ctrl against a transfer-level model
module tb_mux16_rr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] din = '0;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_mask = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic        out_data;
    logic [3:0]  out_chan;
    logic [15:0] gnt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    mux16_rr_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .cfg_we    (cfg_we),
        .cfg_mask  (cfg_mask),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .gnt       (gnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Transfer-level model: m_age < 0 means no transfer, 0 means the winner
    // was just picked, >= 1 means the result is being presented.
    logic [15:0] m_mask  = 16'hFFFF;
    int          m_ptr   = 15;
    int          m_age   = -1;
    int          m_sel   = 0;
    logic        m_valid = 1'b0;
    logic        m_data  = 1'b0;
    int          m_chan  = 0;
    logic [15:0] m_gnt   = '0;

    always @(posedge clk) begin
        logic [15:0] elig;
        logic [15:0] nxt_gnt;
        int          k;
        if (!rst_n) begin
            m_mask  = 16'hFFFF;
            m_ptr   = 15;
            m_age   = -1;
            m_valid = 1'b0;
            m_data  = 1'b0;
            m_chan  = 0;
            m_gnt   = '0;
        end else begin
            nxt_gnt = '0;
            if (m_age < 0) begin
                elig = req & m_mask;
                if (elig != 0) begin
                    k = 1;
                    while (!elig[(m_ptr + k) % 16]) k++;
                    m_sel = (m_ptr + k) % 16;
                    m_age = 0;
                end
            end else if (m_age == 0) begin
                m_data  = din[m_sel];
                m_chan  = m_sel;
                m_valid = 1'b1;
                m_age   = 1;
            end else if (out_ready) begin
                nxt_gnt = 16'(1) << m_sel;
                m_ptr   = m_sel;
                m_valid = 1'b0;
                m_age   = -1;
            end else begin
                m_age++;
            end
            m_gnt = nxt_gnt;
            if (cfg_we) m_mask = cfg_mask;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic step();
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_chan",  32'(out_chan),  32'(m_chan));
        chk("gnt",       32'(gnt),       32'(m_gnt));
        chk("busy",      32'(busy),      32'(m_age >= 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (gnt == 0 && n < 30);
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < 30);
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [15:0] seq32 [5];

        // Reset state
        step();
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_chan",  32'(out_chan),  32'd0);

        // Single request: valid two cycles after arbitration, gnt one later
        req = 16'h0001; din = 16'h0001; out_ready = 1'b1;
        step();
        chk("lat_c1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_c2_valid", 32'(out_valid), 32'd1);
        chk("lat_c2_chan",  32'(out_chan),  32'd0);
        chk("lat_c2_data",  32'(out_data),  32'd1);
        step();
        chk("lat_gnt", 32'(gnt), 32'h0001);
        req = '0;
        step();
        chk("gnt_one_cycle", 32'(gnt), 32'd0);

        // Alternation with wrap between channels 0 and 15
        do_reset();
        req = 16'h8001; out_ready = 1'b1;
        wait_gnt("alt0", 16'h0001);
        wait_gnt("alt1", 16'h8000);
        wait_gnt("alt2", 16'h0001);
        wait_gnt("alt3", 16'h8000);
        req = '0;

        // Mask write: the same-edge arbitration still sees the old mask
        do_reset();
        req = 16'hFFFF; cfg_we = 1'b1; cfg_mask = 16'h00F0;
        step();
        cfg_we = 1'b0;
        seq32[0] = 16'h0001; seq32[1] = 16'h0010; seq32[2] = 16'h0020;
        seq32[3] = 16'h0040; seq32[4] = 16'h0080;
        for (int i = 0; i < 5; i++) wait_gnt($sformatf("mask_seq%0d", i), seq32[i]);
        wait_gnt("mask_wrap", 16'h0010);
        req = '0;

        // Back-pressure: presented data stays frozen while inputs toggle
        do_reset();
        req = 16'h0008; din = 16'h0008; out_ready = 1'b0;
        wait_valid("bp_valid");
        for (int i = 0; i < 10; i++) begin
            din ^= 16'h0008;
            req ^= 16'h0008;
            step();
            chk("bp_chan", 32'(out_chan), 32'd3);
            chk("bp_data", 32'(out_data), 32'd1);
            chk("bp_gnt",  32'(gnt),      32'd0);
        end
        req = '0;
        out_ready = 1'b1;
        wait_gnt("bp_release", 16'h0008);

        // Reset while presenting discards the transfer
        do_reset();
        req = 16'h0030; out_ready = 1'b0;
        wait_valid("rs_valid");
        rst_n = 1'b0;
        step();
        chk("rs_valid0", 32'(out_valid), 32'd0);
        chk("rs_gnt0",   32'(gnt),       32'd0);
        chk("rs_busy0",  32'(busy),      32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        wait_gnt("rs_first", 16'h0010);
        req = '0;

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            req       = 16'($urandom) & 16'($urandom);
            din       = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cfg_we    = ($urandom_range(0, 39) == 0);
            cfg_mask  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; cfg_we = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
